// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arb
// Purpose  : Shares one memory bus master between the instruction-fetch (IM)
//            and data-memory (DM) ports. Each access runs an address phase
//            (req/gnt) then a response phase (rvalid). DM has fixed priority.
// Option   : define MEM_ARB_TIMEOUT_EN to abort transactions that exceed
//            TIMEOUT_CYC cycles and raise a sticky err_o.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WEB_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_rdata,
  output logic              im_done,
  output logic              im_stall,
  // data-memory port
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [WEB_W-1:0]  dm_web,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  // shared bus master
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WEB_W-1:0]  m_web,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_IM = 1'b0;
  localparam logic OWN_DM = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                m_wr_q, m_wr_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [WEB_W-1:0]    m_web_q, m_web_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]   im_rdata_q, im_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                im_done_q, im_done_d;
  logic                dm_done_q, dm_done_d;
  logic                complete;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Next-state, arbitration, completion and (optionally) timeout logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_wr_d     = m_wr_q;
    m_addr_d   = m_addr_q;
    m_web_d    = m_web_q;
    m_wdata_d  = m_wdata_q;
    im_rdata_d = im_rdata_q;
    dm_rdata_d = dm_rdata_q;
    im_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    complete   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The done cycle is spent idle; a request still present next cycle
        // is a fresh access.
        if (!(im_done_q || dm_done_q)) begin
          if (dm_rd || dm_wr) begin
            owner_d   = OWN_DM;
            m_addr_d  = dm_addr;
            m_wr_d    = dm_wr;             // rd+wr together counts as write
            m_web_d   = dm_wr ? dm_web : {WEB_W{1'b1}};
            m_wdata_d = dm_wdata;
            state_d   = ST_ADDR;
          end else if (im_req) begin
            owner_d   = OWN_IM;
            m_addr_d  = im_addr;
            m_wr_d    = 1'b0;
            m_web_d   = {WEB_W{1'b1}};
            state_d   = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (m_gnt) begin
          complete = m_rvalid;
          state_d  = m_rvalid ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_rvalid) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      if (owner_q == OWN_DM) begin
        dm_done_d = 1'b1;
        if (!m_wr_q) dm_rdata_d = m_rdata;
      end else begin
        im_done_d  = 1'b1;
        im_rdata_d = m_rdata;
      end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    err_d = err_q;
    // Counting from zero in IDLE is the same as clearing on ADDR entry,
    // since ADDR is only reachable from IDLE.
    cnt_d = (state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
    if ((state_q != ST_IDLE) && !complete && (cnt_q == CNT_LAST)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      if (owner_q == OWN_DM) begin
        dm_done_d = 1'b1;
        if (!m_wr_q) dm_rdata_d = '0;
      end else begin
        im_done_d  = 1'b1;
        im_rdata_d = '0;
      end
    end
`endif
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IM;
      m_wr_q     <= 1'b0;
      m_addr_q   <= '0;
      m_web_q    <= {WEB_W{1'b1}};
      m_wdata_q  <= '0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
      im_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      m_wr_q     <= m_wr_d;
      m_addr_q   <= m_addr_d;
      m_web_q    <= m_web_d;
      m_wdata_q  <= m_wdata_d;
      im_rdata_q <= im_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      im_done_q  <= im_done_d;
      dm_done_q  <= dm_done_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign m_req    = (state_q == ST_ADDR);
  assign m_wr     = m_wr_q;
  assign m_addr   = m_addr_q;
  assign m_web    = m_web_q;
  assign m_wdata  = m_wdata_q;
  assign im_rdata = im_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign im_done  = im_done_q;
  assign dm_done  = dm_done_q;
  assign im_stall = im_req & ~im_done_q;
  assign dm_stall = (dm_rd | dm_wr) & ~dm_done_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arb
// Purpose  : Directed self-checking bench for mem_port_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_done, im_stall;
  logic        dm_rd, dm_wr;
  logic [31:0] dm_addr;
  logic [3:0]  dm_web;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done, dm_stall;
  logic        m_req, m_wr;
  logic [31:0] m_addr;
  logic [3:0]  m_web;
  logic [31:0] m_wdata;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  logic        err_o;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arb #(
    .ADDR_W(32), .DATA_W(32), .WEB_W(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .im_done(im_done), .im_stall(im_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_web(dm_web),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .dm_stall(dm_stall),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_web(m_web),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; im_req = 0; im_addr = '0; dm_rd = 0; dm_wr = 0;
    dm_addr = '0; dm_web = 4'hF; dm_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    tick(); tick();

    // ---- reset state
    check("rst_m_req",   m_req,    0);
    check("rst_m_wr",    m_wr,     0);
    check("rst_m_addr",  m_addr,   0);
    check("rst_m_web",   m_web,    4'hF);
    check("rst_m_wdata", m_wdata,  0);
    check("rst_im_done", im_done,  0);
    check("rst_dm_done", dm_done,  0);
    check("rst_im_rd",   im_rdata, 0);
    check("rst_dm_rd",   dm_rdata, 0);
    check("rst_err",     err_o,    0);
    rst = 1'b1;
    tick();

    // ---- IM fetch, zero-wait bus
    im_req = 1; im_addr = 32'h100;                  // cycle 0
    tick();                                         // cycle 1
    check("im1_m_req",   m_req,   1);
    check("im1_m_addr",  m_addr,  32'h100);
    check("im1_m_web",   m_web,   4'hF);
    check("im1_m_wr",    m_wr,    0);
    check("im1_stall",   im_stall, 1);
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h13;
    tick();                                         // cycle 2
    check("im1_done",    im_done,  1);
    check("im1_rdata",   im_rdata, 32'h13);
    check("im1_stall_d", im_stall, 0);
    check("im1_m_req_d", m_req,    0);
    im_req = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    tick();                                         // cycle 3
    check("im1_done_off", im_done,  0);
    check("im1_rd_hold",  im_rdata, 32'h13);

    // ---- DM store with wait states
    dm_wr = 1; dm_addr = 32'h8004; dm_web = 4'b1100; dm_wdata = 32'hBEEF;
    tick();                                         // ADDR 1
    check("st_m_req1",  m_req,   1);
    check("st_m_wr",    m_wr,    1);
    check("st_m_web",   m_web,   4'b1100);
    check("st_m_wdata", m_wdata, 32'hBEEF);
    check("st_m_addr",  m_addr,  32'h8004);
    check("st_stall",   dm_stall, 1);
    dm_wdata = 32'h0; dm_web = 4'hF;                // latched fields must not follow
    tick();                                         // ADDR 2
    check("st_m_req2",   m_req,   1);
    check("st_wdata2",   m_wdata, 32'hBEEF);
    check("st_web2",     m_web,   4'b1100);
    tick();                                         // ADDR 3
    check("st_m_req3",   m_req,   1);
    m_gnt = 1;
    tick();                                         // RESP 1
    m_gnt = 0;
    check("st_resp_req", m_req,   0);
    check("st_nodone1",  dm_done, 0);
    tick();                                         // RESP 2
    check("st_nodone2",  dm_done, 0);
    tick();                                         // RESP 3
    check("st_nodone3",  dm_done, 0);
    m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    tick();                                         // done
    check("st_done",     dm_done,  1);
    check("st_rd_keep",  dm_rdata, 0);
    check("st_stall_d",  dm_stall, 0);
    dm_wr = 0; m_rvalid = 0; m_rdata = '0;
    tick();                                         // IDLE
    check("st_done_off", dm_done, 0);

    // ---- IM and DM together, zero-wait bus, gnt+rvalid held high
    im_req = 1; im_addr = 32'h200; dm_rd = 1; dm_addr = 32'h40;
    tick();                                         // cycle 1: DM address
    check("both_addr",   m_addr,  32'h40);
    check("both_wr",     m_wr,    0);
    check("both_web",    m_web,   4'hF);
    check("both_imst1",  im_stall, 1);
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'hCAFE0001;
    tick();                                         // cycle 2: dm_done
    check("both_dmdone", dm_done,  1);
    check("both_dmrd",   dm_rdata, 32'hCAFE0001);
    check("both_imdn0",  im_done,  0);
    check("both_imst2",  im_stall, 1);
    dm_rd = 0; m_rdata = 32'h11110002;
    tick();                                         // cycle 3: IDLE, arbitrates IM
    check("both_dmdn_off", dm_done, 0);
    check("both_req3",     m_req,   0);
    check("both_imst3",    im_stall, 1);
    tick();                                         // cycle 4: IM address
    check("both_imaddr",   m_addr,  32'h200);
    check("both_req4",     m_req,   1);
    tick();                                         // cycle 5: im_done
    check("both_imdone",   im_done,  1);
    check("both_imrd",     im_rdata, 32'h11110002);
    check("both_dmrd_hold", dm_rdata, 32'hCAFE0001);
    check("both_imst5",    im_stall, 0);
    im_req = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    tick();

    // ---- reset during RESP, late rvalid after release
    dm_rd = 1; dm_addr = 32'h300;
    tick();                                         // ADDR
    m_gnt = 1;
    tick();                                         // RESP
    check("rr_resp_req", m_req, 0);
    m_gnt = 0; rst = 0; dm_rd = 0;
    tick();                                         // in reset
    check("rr_m_addr",   m_addr,   0);
    check("rr_dm_rd",    dm_rdata, 0);
    check("rr_im_rd",    im_rdata, 0);
    rst = 1; m_rvalid = 1; m_rdata = 32'h5555;
    tick();                                         // rvalid seen in IDLE
    check("rr_dmdone",   dm_done, 0);
    check("rr_imdone",   im_done, 0);
    m_rvalid = 0; m_rdata = '0;
    tick();
    check("rr_dmdone2",  dm_done,  0);
    check("rr_dm_rd2",   dm_rdata, 0);
    check("rr_m_req",    m_req,    0);
    check("rr_m_web",    m_web,    4'hF);
    check("rr_m_wr",     m_wr,     0);
    check("rr_err",      err_o,    0);

`ifdef MEM_ARB_TIMEOUT_EN
    // ---- timeout: grant never arrives
    dm_rd = 1; dm_addr = 32'h400; m_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 8; c++) begin
      tick();                                       // ADDR cycles 1..8
      check("to_wait_done", dm_done, 0);
      check("to_wait_req",  m_req,   1);
    end
    tick();                                         // cycle 9
    check("to_done",  dm_done,  1);
    check("to_rdata", dm_rdata, 0);
    check("to_err",   err_o,    1);
    check("to_req",   m_req,    0);
    dm_rd = 0;
    tick(); tick();
    check("to_err_hold", err_o, 1);
    rst = 0;
    tick();
    check("to_err_clr", err_o, 0);
    rst = 1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates the CPU's instruction-fetch port (IM, read-only) and data-memory port (DM, load/store) onto one shared memory bus master.
- Sequences each access through an address phase (req/gnt) and a response phase (rvalid).
- Returns read data and a one-cycle done pulse to the owning requester.
- Drives per-port stall signals, which the pipeline uses to hold the IF stage and the MEM/WB enable.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WEB_W, 4, byte write-enable width, active-low as in the DM port
- TIMEOUT_CYC, 255, maximum cycles per transaction (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- im_req  in  1  fetch request; held until im_done
- im_addr  in  ADDR_W  fetch address
- im_rdata  out  DATA_W  fetched word; valid with im_done, then held
- im_done  out  1  one-cycle completion pulse
- im_stall  out  1  im_req & ~im_done
- dm_rd  in  1  load request; held until dm_done
- dm_wr  in  1  store request; held until dm_done
- dm_addr  in  ADDR_W  data address
- dm_web  in  WEB_W  byte write enables, active-low
- dm_wdata  in  DATA_W  store data, already lane-aligned
- dm_rdata  out  DATA_W  load word, raw and not extended; valid with dm_done, then held
- dm_done  out  1  one-cycle completion pulse
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
- m_req  out  1  bus address-phase request
- m_wr  out  1  1 = write
- m_addr  out  ADDR_W  bus address
- m_web  out  WEB_W  bus write enables; all ones for reads
- m_wdata  out  DATA_W  bus write data
- m_gnt  in  1  address phase accepted
- m_rvalid  in  1  response; also serves as the write acknowledge
- m_rdata  in  DATA_W  read data
- err_o  out  1  sticky timeout error

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE.
  - m_req, m_wr, im_done, dm_done, err_o = 0.
  - m_addr, m_wdata, im_rdata, dm_rdata = 0; m_web = all ones.
  - Any in-flight transaction is abandoned.
  - An m_rvalid arriving in IDLE after reset is ignored.
- FSM states: IDLE, ADDR, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If dm_rd|dm_wr: owner=DM. Latch m_addr=dm_addr, m_wr=dm_wr, m_web=(dm_wr ? dm_web : all ones), m_wdata=dm_wdata. Go to ADDR.
  - Else if im_req: owner=IM. Latch m_addr=im_addr, m_wr=0, m_web=all ones. Go to ADDR.
  - DM has fixed priority, because it is the older instruction.
  - dm_rd and dm_wr both high is illegal; it is treated as a write.
- ADDR:
  - m_req=1, and the latched fields are held stable until m_gnt.
  - On m_gnt: m_req=0 next cycle, go to RESP.
  - If m_gnt and m_rvalid arrive in the same cycle: complete as in RESP and go to IDLE.
- RESP:
  - On m_rvalid: capture m_rdata into the owner's rdata register, but only for reads; writes leave it unchanged.
  - Pulse the owner's done for exactly the next cycle, and go to IDLE.
- Latency: request seen in IDLE → m_req asserted next cycle. Zero-wait bus (gnt and rvalid on the first m_req cycle) → done 2 cycles after the request.
- After done, the FSM sits in IDLE for one cycle before it can arbitrate again. Back-to-back throughput is 1 access per 3 cycles with a zero-wait bus.
- done cycle: the requester's stall is low and the pipeline advances. A request present in the following cycle is treated as a new access.
- Both ports requesting: DM is served first. IM stays stalled and is served after dm_done, provided DM does not re-request that cycle.
- Request inputs are not sampled outside IDLE. Deasserting a request before done is a protocol violation; the FSM still completes the bus transaction.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ADDR and increments every cycle in ADDR/RESP.
  - When it reaches TIMEOUT_CYC with no completion: pulse the owner's done, set the owner's rdata to 0 (reads only), drop m_req, go to IDLE.
  - err_o is set and stays 1 until reset.
  - A late m_rvalid arriving in IDLE is ignored.
- Undefined: no counter; the FSM waits indefinitely; err_o is tied to 0.

Test Plan:
- IM only, im_addr=0x100, gnt and rvalid on the first m_req cycle, rdata=0x00000013 → m_req in cycle 1, im_done in cycle 2, im_rdata=0x13, m_web=4'hF.
- DM store, dm_addr=0x8004, dm_web=4'b1100, dm_wdata=0x0000BEEF, gnt after 2 cycles, rvalid after 3 more → m_wr=1, m_web=4'b1100, m_wdata=0xBEEF stable through ADDR; dm_done once; dm_rdata unchanged.
- im_req and dm_rd asserted in the same cycle → DM transaction first, then IM; im_stall=1 until im_done.
- Zero-wait bus, DM load then IM fetch with both requests held → done pulses 3 cycles apart, m_gnt and m_rvalid arriving together on each.
- rst low while in RESP, then m_rvalid the cycle after rst releases → state IDLE, no done pulse, all outputs at their reset values.
- MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=8, m_gnt never asserted → dm_done in cycle 9 of ADDR, dm_rdata=0, err_o=1 held until reset.
